mult_div_sequencer: RTL and testbench
=====================================

// Module: mult_div_sequencer
// PURPOSE
//  Sequences the shared multiply/divide resource (Multi and Div units plus HI/LO registers) on behalf of
//  the main control unit. Accepts one mult/div request, checks the divisor for zero, pulses the selected
//  unit's start, waits for its stop with a watchdog, commits HI/LO, then reports done or a fault.
//  Sits between the main control FSM and the Multi/Div/HI/LO blocks; the control FSM stalls while busy is high.
// PARAMETERS
//  TIMEOUT_CYCLES  40  max WAIT cycles before a timeout fault (Multi/Div need at most 33)
//  CNT_W           6   watchdog counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clock       in   1   system clock, rising edge
//  reset       in   1   asynchronous, active-high reset
//  req         in   1   start-operation request from control unit, sampled only in IDLE
//  op          in   1   0 = MULT, 1 = DIV; captured with req
//  divisor     in   32  B-register value, zero-checked when req && op==DIV
//  mult_start  out  1   one-cycle start pulse to Multi
//  div_start   out  1   one-cycle start pulse to Div
//  mult_stop   in   1   Multi finished; HI/LO inputs valid this cycle
//  div_stop    in   1   Div finished; HI/LO inputs valid this cycle
//  hi_write    out  1   load enable of HI register
//  lo_write    out  1   load enable of LO register
//  busy        out  1   high in LAUNCH, WAIT, COMMIT
//  done        out  1   one-cycle pulse: HI/LO updated
//  div_zero    out  1   one-cycle pulse: divide by zero, HI/LO untouched
//  timeout     out  1   one-cycle pulse: selected unit never raised stop
// BEHAVIOUR
//  - State register and op_q, cnt flops reset asynchronously. All outputs are Moore decodes of state and op_q.
//    Every output is 0 in reset and in IDLE.
//  - States: IDLE, LAUNCH, WAIT, COMMIT, FINISH, FAULT.
//  - IDLE: on req, capture op into op_q.
//    * If op==DIV and divisor==32'd0: go to FAULT and set flt_q = DIVZ.
//    * Otherwise go to LAUNCH. No req: stay in IDLE.
//  - LAUNCH (1 cycle): mult_start = (op_q==MULT), div_start = (op_q==DIV); clear cnt; go to WAIT.
//  - WAIT: cnt += 1 each cycle. Only the stop of the selected unit (sel_stop) is honoured; the other is ignored.
//    * sel_stop: go to COMMIT.
//    * Else if cnt == TIMEOUT_CYCLES-1: go to FAULT and set flt_q = TMO.
//    * sel_stop in the same cycle as the limit: stop wins, go to COMMIT.
//  - COMMIT (1 cycle): hi_write = lo_write = 1; go to FINISH.
//    The Multi/Div units hold HI/LO until their next start, so the values are stable in this cycle.
//  - FINISH (1 cycle): done = 1; go to IDLE.
//  - FAULT (1 cycle): div_zero = (flt_q==DIVZ), timeout = (flt_q==TMO); go to IDLE. hi_write/lo_write never assert.
//  - Latency: req at cycle 0 -> start at 1 -> stop at k (k>=2) -> hi/lo write at k+1 -> done at k+2.
//    Div-by-zero: req at 0 -> div_zero at 1.
//  - req outside IDLE (busy, FINISH, FAULT) is dropped, not queued. The control unit must wait for done, div_zero or timeout.
//  - Reset mid-operation: back to IDLE immediately with all outputs 0. The started unit is cleared by the same reset.
//  - Exactly one of done, div_zero, timeout pulses per accepted req.
//    The start pulses are mutually exclusive; start and write are never asserted together.
// STRUCTURE
//  - Shared package/include: state encoding localparams, OP_MULT=1'b0, OP_DIV=1'b1, fault codes DIVZ/TMO.
//    These are reused by the control unit for its stall and exception paths.
//  - No sub-module: watchdog counter and zero-compare stay inline. One clocked state process, one combinational next-state/output process.
// TESTING
//  - MULT: req, op=0, model mult_stop at cycle 34 -> mult_start at 1 only, hi/lo_write at 35, done at 36, busy 1..35.
//  - DIV: req, op=1, divisor=7, div_stop at cycle 5 -> div_start at 1, hi/lo_write at 6, done at 7, mult_start never high.
//  - Div by zero: req, op=1, divisor=0 -> div_zero at 1, no div_start, no hi/lo_write, IDLE at 2.
//  - Timeout: req, op=0, mult_stop held 0 -> timeout pulse once 40 WAIT cycles have elapsed, no writes.
//    Repeat with mult_stop on the 40th WAIT cycle -> COMMIT, done, no timeout.
//  - Wrong stop and dropped req: op=1 with div_stop held 0 while mult_stop pulses, and req pulsed during WAIT.
//    Both are ignored; a single done follows div_stop.
//  - Reset at WAIT cycle 10 -> all outputs 0 asynchronously. A new req after release runs a full sequence normally.

Source files
------------

// File: rtl/mult_div_sequencer_pkg.sv
// Shared encodings for the mult/div sequencer.
// Holds the state codes, operation select values and fault codes. The main
// control unit imports the same constants for its stall and exception paths.
package mult_div_sequencer_pkg;

    localparam int unsigned STATE_W = 3;

    // Sequencer states
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LAUNCH = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_COMMIT = 3'd3;
    localparam logic [STATE_W-1:0] ST_FINISH = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT  = 3'd5;

    // Operation select, captured with req
    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    // Fault cause reported from FAULT
    localparam logic FLT_DIVZ = 1'b0;
    localparam logic FLT_TMO  = 1'b1;

endpackage

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
// Sequences the shared Multi/Div units and the HI/LO registers for the main
// control unit: accepts one request, rejects divide-by-zero up front, pulses
// the selected unit's start, waits for its stop under a watchdog, commits
// HI/LO and then reports done, div_zero or timeout.
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req, op, divisor      request, operation (0 MULT / 1 DIV), divisor value
//   mult_start, div_start one-cycle start pulses to Multi / Div
//   mult_stop, div_stop   completion strobes from Multi / Div
//   hi_write, lo_write    HI/LO load enables
//   busy                  high while an operation is in flight
//   done, div_zero, timeout  one-cycle completion / fault pulses
module mult_div_sequencer
    import mult_div_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 40,
    parameter int unsigned CNT_W          = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        op,
    input  logic [31:0] divisor,
    output logic        mult_start,
    output logic        div_start,
    input  logic        mult_stop,
    input  logic        div_stop,
    output logic        hi_write,
    output logic        lo_write,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               op_q, op_d;
    logic               flt_q, flt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sel_stop_c;

    logic mult_start_d, div_start_d, write_d, busy_d;
    logic done_d, div_zero_d, timeout_d;

    // Only the stop of the unit that was actually started counts
    assign sel_stop_c = (op_q == OP_DIV) ? div_stop : mult_stop;

    // Next-state logic plus output decode of the next state, so the
    // registered outputs line up with the state they belong to
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        flt_d   = flt_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    op_d = op;
                    if ((op == OP_DIV) && (divisor == 32'd0)) begin
                        state_d = ST_FAULT;
                        flt_d   = FLT_DIVZ;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A stop arriving on the limit cycle still completes normally
                if (sel_stop_c) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_FAULT;
                    flt_d   = FLT_TMO;
                end
            end
            ST_COMMIT: state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            ST_FAULT:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        mult_start_d = (state_d == ST_LAUNCH) && (op_d == OP_MULT);
        div_start_d  = (state_d == ST_LAUNCH) && (op_d == OP_DIV);
        write_d      = (state_d == ST_COMMIT);
        busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_WAIT) ||
                       (state_d == ST_COMMIT);
        done_d       = (state_d == ST_FINISH);
        div_zero_d   = (state_d == ST_FAULT) && (flt_d == FLT_DIVZ);
        timeout_d    = (state_d == ST_FAULT) && (flt_d == FLT_TMO);
    end

    // State, context and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MULT;
            flt_q      <= FLT_DIVZ;
            cnt_q      <= '0;
            mult_start <= 1'b0;
            div_start  <= 1'b0;
            hi_write   <= 1'b0;
            lo_write   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            flt_q      <= flt_d;
            cnt_q      <= cnt_d;
            mult_start <= mult_start_d;
            div_start  <= div_start_d;
            hi_write   <= write_d;
            lo_write   <= write_d;
            busy       <= busy_d;
            done       <= done_d;
            div_zero   <= div_zero_d;
            timeout    <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer
// Scoreboard bench: each request pushes the output pulses it should cause
// (kind + absolute cycle); a negedge monitor pops and compares every pulse
// the sequencer actually produces. busy is checked cycle by cycle.
module tb_mult_div_sequencer;

    localparam int K_MSTART = 1;
    localparam int K_DSTART = 2;
    localparam int K_HI     = 3;
    localparam int K_LO     = 4;
    localparam int K_DONE   = 5;
    localparam int K_DIVZ   = 6;
    localparam int K_TMO    = 7;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic        clock;
    logic        reset;
    logic        req;
    logic        op;
    logic [31:0] divisor;
    logic        mult_start, div_start;
    logic        mult_stop, div_stop;
    logic        hi_write, lo_write;
    logic        busy, done, div_zero, timeout;

    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;
    ev_t exp_q[$];

    mult_div_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .op         (op),
        .divisor    (divisor),
        .mult_start (mult_start),
        .div_start  (div_start),
        .mult_stop  (mult_stop),
        .div_stop   (div_stop),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .timeout    (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic see(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'(kind), 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", 32'(kind), 32'(e.kind));
            chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    // Monitor: every asserted pulse output must match the scoreboard head
    always @(negedge clock) begin
        if (!reset) begin
            if (mult_start) see(K_MSTART);
            if (div_start)  see(K_DSTART);
            if (hi_write)   see(K_HI);
            if (lo_write)   see(K_LO);
            if (done)       see(K_DONE);
            if (div_zero)   see(K_DIVZ);
            if (timeout)    see(K_TMO);
        end
    end

    // One request; stop_at/wrong_at/drop_at/rst_at are cycles relative to
    // the req cycle, -1 meaning never.
    task automatic run_op(input logic o, input logic [31:0] dv, input int stop_at,
                          input int wrong_at, input int drop_at, input int rst_at);
        int t0;
        int last;
        bit divz;
        bit tmo;
        t0   = cyc;
        divz = (o == 1'b1) && (dv == 32'd0);
        tmo  = !divz && ((stop_at < 2) || (stop_at > 41));
        if (divz) begin
            push(K_DIVZ, t0 + 1);
            last = 1;
        end else begin
            push(o ? K_DSTART : K_MSTART, t0 + 1);
            if (tmo) begin
                last = 42;
                if (rst_at < 0) push(K_TMO, t0 + 42);
            end else begin
                last = stop_at + 2;
                if (rst_at < 0) begin
                    push(K_HI,   t0 + stop_at + 1);
                    push(K_LO,   t0 + stop_at + 1);
                    push(K_DONE, t0 + stop_at + 2);
                end
            end
        end

        for (int rel = 0; rel <= last + 2; rel++) begin
            req       = (rel == 0) || (rel == drop_at);
            op        = o;
            divisor   = dv;
            mult_stop = (o == 1'b0) ? (rel == stop_at) : (rel == wrong_at);
            div_stop  = (o == 1'b1) ? (rel == stop_at) : (rel == wrong_at);
            if (rel == rst_at) begin
                #2 reset = 1'b1;
                #1 chk("async_reset_outputs",
                       32'({mult_start, div_start, hi_write, lo_write,
                            busy, done, div_zero, timeout}), 32'd0);
                req       = 1'b0;
                mult_stop = 1'b0;
                div_stop  = 1'b0;
                repeat (2) @(posedge clock);
                #1 reset = 1'b0;
                break;
            end
            @(negedge clock);
            chk("busy", 32'(busy), 32'(!divz && (rel >= 1) && (rel <= last - 1)));
            @(posedge clock);
            #1;
        end
        req       = 1'b0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        req       = 1'b0;
        op        = 1'b0;
        divisor   = 32'd0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs",
            32'({mult_start, div_start, hi_write, lo_write,
                 busy, done, div_zero, timeout}), 32'd0);
        reset = 1'b0;

        run_op(1'b0, 32'd0,   34, -1, -1, -1);   // MULT, stop at 34
        run_op(1'b1, 32'd7,    5, -1, -1, -1);   // DIV, stop at 5
        run_op(1'b1, 32'd0,   -1, -1, -1, -1);   // divide by zero
        run_op(1'b0, 32'd5,   -1, -1, -1, -1);   // watchdog timeout
        run_op(1'b0, 32'd5,   41, -1, -1, -1);   // stop on the limit cycle
        run_op(1'b1, 32'd9,   12,  6,  8, -1);   // wrong stop + dropped req
        run_op(1'b0, 32'd3,   -1, -1, -1, 11);   // reset at WAIT cycle 10
        run_op(1'b1, 32'd100, 20, -1, -1, -1);   // full sequence after reset

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
